ik_iter_seq: RTL

Iteration sequencer between the Avalon register interface and the `ik_swift` Jacobian core. It takes an initial joint-angle vector and a start pulse, then repeatedly launches the core with the current angles. After each run it applies the returned per-joint deltas, clamping and wrapping each angle to ±π. It stops on convergence or when the iteration limit is reached, and reports the final angles, iteration count and status to software.

---
 rtl/ik_iter_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ik_iter_seq.sv
// rtl/ik_iter_seq.sv - iteration sequencer launching ik_swift and integrating its joint deltas
// Optional core-handshake watchdog: define IK_ITER_WATCHDOG_EN.
module ik_iter_seq #(
   parameter int NJ        = 6,
   parameter int W         = 21,
   parameter int PI_FX     = 205887,
   parameter int MAX_STEP  = 16384,
   parameter int WD_CYCLES = 4096
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [7:0]      max_iter,
   input  logic [W-1:0]    tol,
   input  logic [NJ*W-1:0] theta_init,
   output logic            core_en,
   output logic [NJ*W-1:0] core_theta,
   input  logic            core_done,
   input  logic [NJ*W-1:0] core_delta,
   output logic            busy,
   output logic            done,
   output logic            converged,
   output logic            timeout,
   output logic [7:0]      iter_count,
   output logic [NJ*W-1:0] theta_out
);
   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_UPDATE, S_CHECK, S_DONE
   } state_t;

   localparam logic signed [W-1:0] STEP_P   = W'(MAX_STEP);
   localparam logic signed [W-1:0] STEP_N   = W'(-MAX_STEP);
   localparam logic signed [W:0]   PI_S     = (W+1)'(PI_FX);
   localparam logic signed [W:0]   TWO_PI   = (W+1)'(2 * PI_FX);
   localparam logic [W-1:0]        MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]        MOST_POS = {1'b0, {(W-1){1'b1}}};

   state_t          state;
   logic [NJ*W-1:0] theta;
   logic [NJ*W-1:0] delta_q;
   logic [NJ*W-1:0] theta_next;
   logic [NJ-1:0]   within_q;
   logic [NJ-1:0]   within_next;
   logic [7:0]      max_q;
   logic [W-1:0]    tol_q;

`ifdef IK_ITER_WATCHDOG_EN
   localparam int WDW = $clog2(WD_CYCLES) + 1;
   logic [WDW-1:0] wd_cnt;
   logic           wd_flag;
   assign timeout = wd_flag;
`else
   assign timeout = 1'b0;
`endif

   assign core_theta = theta;
   assign theta_out  = theta;

   // Clamp the step, add at W+1 bits, then fold back once into [-pi, pi].
   function automatic logic [W-1:0] step_angle(input logic [W-1:0] th, input logic [W-1:0] raw);
      logic signed [W-1:0] d;
      logic signed [W:0]   s;
      if ($signed(raw) > STEP_P)
         d = STEP_P;
      else if ($signed(raw) < STEP_N)
         d = STEP_N;
      else
         d = $signed(raw);
      s = $signed({th[W-1], th}) + $signed({d[W-1], d});
      if (s > PI_S)
         s = s - TWO_PI;
      else if (s < -PI_S)
         s = s + TWO_PI;
      return s[W-1:0];
   endfunction

   function automatic logic in_tol(input logic [W-1:0] raw, input logic [W-1:0] lim);
      logic [W-1:0] mag;
      if (raw == MOST_NEG)
         mag = MOST_POS;
      else if (raw[W-1])
         mag = -raw;
      else
         mag = raw;
      return mag <= lim;
   endfunction

   always_comb begin
      theta_next  = theta;
      within_next = '0;
      for (int j = 0; j < NJ; j++) begin
         theta_next[j*W +: W] = step_angle(theta[j*W +: W], delta_q[j*W +: W]);
         within_next[j]       = in_tol(delta_q[j*W +: W], tol_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         theta      <= '0;
         delta_q    <= '0;
         within_q   <= '0;
         max_q      <= '0;
         tol_q      <= '0;
         core_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
         iter_count <= '0;
`ifdef IK_ITER_WATCHDOG_EN
         wd_cnt     <= '0;
         wd_flag    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  iter_count <= '0;
                  converged  <= 1'b0;
                  within_q   <= '0;
                  max_q      <= max_iter;
                  tol_q      <= tol;
`ifdef IK_ITER_WATCHDOG_EN
                  wd_flag    <= 1'b0;
`endif
                  // A zero limit skips the core but still passes CHECK, which ends it with converged=0.
                  if (max_iter != 8'd0) begin
                     theta <= theta_init;
                     state <= S_LAUNCH;
                  end else begin
                     state <= S_CHECK;
                  end
               end
            end
            S_LAUNCH: begin
               core_en <= 1'b1;
`ifdef IK_ITER_WATCHDOG_EN
               wd_cnt  <= '0;
`endif
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  delta_q <= core_delta;
                  state   <= S_UPDATE;
               end
`ifdef IK_ITER_WATCHDOG_EN
               else if (wd_cnt == WDW'(WD_CYCLES - 1)) begin
                  core_en <= 1'b0;
                  wd_flag <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  wd_cnt <= wd_cnt + WDW'(1);
               end
`endif
            end
            S_UPDATE: begin
               core_en    <= 1'b0;
               theta      <= theta_next;
               within_q   <= within_next;
               iter_count <= iter_count + 8'd1;
               state      <= S_CHECK;
            end
            S_CHECK: begin
               if (&within_q) begin
                  converged <= 1'b1;
                  state     <= S_DONE;
               end else if (iter_count == max_q) begin
                  state <= S_DONE;
               end else begin
                  state <= S_LAUNCH;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
